// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: execute-stage <-> M-extension unit handshake bundle.
// master = execute stage, slave = muldiv unit.
interface muldiv_ctrl_if;
    logic        execute_i_start;
    logic [12:0] execute_i_op;
    logic [63:0] execute_i_src1;
    logic [63:0] execute_i_src2;
    logic [4:0]  execute_i_rd;
    logic        execute_i_flush;
    logic        muldiv_o_ready;
    logic        muldiv_o_stall;
    logic        muldiv_o_valid;
    logic [63:0] muldiv_o_result;
    logic [4:0]  muldiv_o_rd;

    modport master (
        output execute_i_start, execute_i_op, execute_i_src1,
        output execute_i_src2, execute_i_rd, execute_i_flush,
        input  muldiv_o_ready, muldiv_o_stall, muldiv_o_valid,
        input  muldiv_o_result, muldiv_o_rd
    );

    modport slave (
        input  execute_i_start, execute_i_op, execute_i_src1,
        input  execute_i_src2, execute_i_rd, execute_i_flush,
        output muldiv_o_ready, muldiv_o_stall, muldiv_o_valid,
        output muldiv_o_result, muldiv_o_rd
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV64 M-extension unit (shift-add mul, restoring div).
// Optional macro MULDIV_FAST_MUL_EN: single-cycle 128-bit multiply.
module muldiv_ctrl (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus_io
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    state_t        state_q;
    logic [12:0]   op_q;
    logic          negq_q, negr_q;
    logic [127:0]  mcand_q, prod_q;
    logic [63:0]   mplier_q, divsr_q, dq_q, rem_q;
    logic [6:0]    cnt_q;
    logic [63:0]   result_q;
    logic [4:0]    rd_q;
    logic          valid_q, ready_q;

    logic [12:0]   op;
    logic [63:0]   src1, src2;
    logic          onehot, accept;
    logic          is_w, is_mul, is_rem, s1s, s2s;
    logic [63:0]   x1, x2, mag1, mag2, dvd;
    logic          sign1, sign2, dz, ovf;
    logic [63:0]   spec_res;
    logic [6:0]    n_calc;

    assign op   = bus_io.execute_i_op;
    assign src1 = bus_io.execute_i_src1;
    assign src2 = bus_io.execute_i_src2;

    assign onehot = (op != '0) && ((op & (op - 13'd1)) == '0);
    assign accept = (state_q == IDLE) && bus_io.execute_i_start
                  && onehot && !bus_io.execute_i_flush;

    assign is_w   = op[8] | op[5] | op[4] | op[1] | op[0];
    assign is_mul = |op[12:8];
    assign is_rem = |op[3:0];
    assign s1s    = op[11] | op[10] | op[7] | op[5] | op[3] | op[1];
    assign s2s    = op[11] | op[7] | op[5] | op[3] | op[1];

    assign x1 = is_w ? {{32{s1s & src1[31]}}, src1[31:0]} : src1;
    assign x2 = is_w ? {{32{s2s & src2[31]}}, src2[31:0]} : src2;
    assign sign1 = s1s & x1[63];
    assign sign2 = s2s & x2[63];
    assign mag1  = sign1 ? (64'd0 - x1) : x1;
    assign mag2  = sign2 ? (64'd0 - x2) : x2;
    assign dvd   = is_w ? {{32{src1[31]}}, src1[31:0]} : src1;

    assign dz  = !is_mul && (is_w ? (src2[31:0] == '0) : (src2 == '0));
    assign ovf = !is_mul && s1s && (is_w
               ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == '1)
               : (src1 == MIN64 && src2 == '1));

    assign spec_res = is_rem ? (dz ? dvd : 64'd0) : (dz ? '1 : dvd);

`ifdef MULDIV_FAST_MUL_EN
    assign n_calc = is_mul ? 7'd1 : (is_w ? 7'd32 : 7'd64);
`else
    assign n_calc = is_w ? 7'd32 : 7'd64;
`endif

    logic [127:0] prod_step, prod_fin, prod_s;
    logic [64:0]  rem_sh;
    logic         ge;
    logic [63:0]  rem_step, dq_step, quo_s, rem_s, fin_res;

    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : 128'd0);
    assign rem_sh    = {rem_q, dq_q[63]};
    assign ge        = rem_sh >= {1'b0, divsr_q};
    assign rem_step  = ge ? (rem_sh[63:0] - divsr_q) : rem_sh[63:0];
    assign dq_step   = {dq_q[62:0], ge};

`ifdef MULDIV_FAST_MUL_EN
    assign prod_fin = {64'd0, mcand_q[63:0]} * {64'd0, mplier_q};
`else
    assign prod_fin = prod_step;
`endif

    assign prod_s = negq_q ? (128'd0 - prod_fin) : prod_fin;
    assign quo_s  = negq_q ? (64'd0 - dq_step) : dq_step;
    assign rem_s  = negr_q ? (64'd0 - rem_step) : rem_step;

    // select the signed-corrected, width-adjusted final result for op_q
    always_comb begin
        fin_res = '0;
        unique case (1'b1)
            op_q[12]:                     fin_res = prod_s[63:0];
            op_q[11], op_q[10], op_q[9]:  fin_res = prod_s[127:64];
            op_q[8]:  fin_res = {{32{prod_s[31]}}, prod_s[31:0]};
            op_q[7], op_q[6]:             fin_res = quo_s;
            op_q[5], op_q[4]: fin_res = {{32{quo_s[31]}}, quo_s[31:0]};
            op_q[3], op_q[2]:             fin_res = rem_s;
            op_q[1], op_q[0]: fin_res = {{32{rem_s[31]}}, rem_s[31:0]};
            default:                      fin_res = '0;
        endcase
    end

    // control FSM plus iterative datapath with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            divsr_q  <= '0;
            dq_q     <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        op_q     <= op;
                        rd_q     <= bus_io.execute_i_rd;
                        negq_q   <= sign1 ^ sign2;
                        negr_q   <= sign1;
                        mcand_q  <= {64'd0, mag1};
                        mplier_q <= mag2;
                        prod_q   <= '0;
                        divsr_q  <= mag2;
                        dq_q     <= is_w ? {mag1[31:0], 32'd0} : mag1;
                        rem_q    <= '0;
                        cnt_q    <= n_calc;
                        ready_q  <= 1'b0;
                        if (dz || ovf) begin
                            state_q  <= DONE;
                            result_q <= spec_res;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus_io.execute_i_flush) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        prod_q   <= prod_step;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        rem_q    <= rem_step;
                        dq_q     <= dq_step;
                        cnt_q    <= cnt_q - 7'd1;
                        if (cnt_q == 7'd1) begin
                            state_q  <= DONE;
                            result_q <= fin_res;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus_io.muldiv_o_ready  = ready_q;
    assign bus_io.muldiv_o_stall  = accept || (state_q == CALC);
    assign bus_io.muldiv_o_valid  = valid_q;
    assign bus_io.muldiv_o_result = result_q;
    assign bus_io.muldiv_o_rd     = rd_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized self-checking bench for muldiv_ctrl.
// Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_ctrl;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus_if ();

    muldiv_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if)
    );

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // reference: RISC-V M semantics with plain arithmetic; k = op bit index
    function automatic logic [63:0] model(input int k, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0]        p;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  wa, wb;
        logic [31:0]         ua, ub, t;
        logic [63:0]         r;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
        ua = a[31:0]; ub = b[31:0];
        r = '0;
        case (k)
            12: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0]; end
            11: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            10: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
            9:  begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            8:  begin t = ua * ub; r = sx32(t); end
            7: begin
                if (b == 0) r = '1;
                else if (a == MIN64 && b == '1) r = a;
                else r = sa / sb;
            end
            6: r = (b == 0) ? '1 : a / b;
            5: begin
                if (ub == 0) r = '1;
                else if (ua == 32'h8000_0000 && ub == '1) r = sx32(ua);
                else begin t = wa / wb; r = sx32(t); end
            end
            4: begin
                if (ub == 0) r = '1;
                else begin t = ua / ub; r = sx32(t); end
            end
            3: begin
                if (b == 0) r = a;
                else if (a == MIN64 && b == '1) r = '0;
                else r = sa % sb;
            end
            2: r = (b == 0) ? a : a % b;
            1: begin
                if (ub == 0) r = sx32(ua);
                else if (ua == 32'h8000_0000 && ub == '1) r = '0;
                else begin t = wa % wb; r = sx32(t); end
            end
            0: begin
                if (ub == 0) r = sx32(ua);
                else begin t = ua % ub; r = sx32(t); end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // expected cycles from accept edge to the DONE edge
    function automatic int nlat(input int k, input logic [63:0] a,
                                input logic [63:0] b);
        bit w, sgn, sp;
        w   = (k == 8 || k == 5 || k == 4 || k == 1 || k == 0);
        sgn = (k == 7 || k == 5 || k == 3 || k == 1);
        if (k >= 8) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return w ? 32 : 64;
`endif
        end
        if (w)
            sp = (b[31:0] == 0) ||
                 (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        else
            sp = (b == 0) || (sgn && a == MIN64 && b == '1);
        if (sp) return 0;
        return w ? 32 : 64;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return MIN64;
            3: return {$urandom, 32'h8000_0000};
            4: return {$urandom, 32'hFFFF_FFFF};
            5: return 64'($urandom_range(0, 50));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic idle_inputs();
        bus_if.execute_i_start = 1'b0;
        bus_if.execute_i_op    = '0;
        bus_if.execute_i_src1  = '0;
        bus_if.execute_i_src2  = '0;
        bus_if.execute_i_rd    = '0;
        bus_if.execute_i_flush = 1'b0;
    endtask

    task automatic drive(input int k, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        bus_if.execute_i_start = 1'b1;
        bus_if.execute_i_op    = 13'd1 << k;
        bus_if.execute_i_src1  = a;
        bus_if.execute_i_src2  = b;
        bus_if.execute_i_rd    = rd;
    endtask

    task automatic run_op(input int k, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp_r, input string nm);
        int n, vat, vcnt, scnt;
        logic [63:0] got_r;
        logic [4:0]  got_rd;
        n = nlat(k, a, b);
        vat = -1; vcnt = 0; scnt = 0;
        got_r = 'x; got_rd = 'x;
        @(posedge clk); #1;
        drive(k, a, b, rd);
        @(negedge clk);
        checks++;
        if (bus_if.muldiv_o_stall !== 1'b1 || bus_if.muldiv_o_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_stall %s: stall=%b ready=%b expected 1/1",
                     nm, bus_if.muldiv_o_stall, bus_if.muldiv_o_ready);
        end
        @(posedge clk); #1;
        bus_if.execute_i_start = 1'b0;
        for (int c = 0; c < n + 3; c++) begin
            @(negedge clk);
            if (bus_if.muldiv_o_valid === 1'b1) begin
                if (vat < 0) vat = c;
                vcnt++;
                got_r  = bus_if.muldiv_o_result;
                got_rd = bus_if.muldiv_o_rd;
            end
            if (bus_if.muldiv_o_stall === 1'b1) scnt++;
        end
        checks++;
        if (vat !== n) begin
            failures++;
            $display("FAIL valid_cycle %s: got %0d expected %0d", nm, vat, n);
        end
        checks++;
        if (vcnt !== 1) begin
            failures++;
            $display("FAIL valid_width %s: got %0d expected 1", nm, vcnt);
        end
        checks++;
        if (scnt !== n) begin
            failures++;
            $display("FAIL stall_cycles %s: got %0d expected %0d", nm, scnt, n);
        end
        checks++;
        if (got_r !== exp_r) begin
            failures++;
            $display("FAIL result %s: got %h expected %h", nm, got_r, exp_r);
        end
        checks++;
        if (got_rd !== rd) begin
            failures++;
            $display("FAIL rd %s: got %0d expected %0d", nm, got_rd, rd);
        end
        checks++;
        if (bus_if.muldiv_o_result !== exp_r || bus_if.muldiv_o_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold %s: result=%h ready=%b expected %h/1",
                     nm, bus_if.muldiv_o_result, bus_if.muldiv_o_ready, exp_r);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string nm);
        int v;
        v = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus_if.muldiv_o_valid !== 1'b0) v++;
        end
        checks++;
        if (v != 0 || bus_if.muldiv_o_ready !== 1'b1) begin
            failures++;
            $display("FAIL quiet %s: valid_cycles=%0d ready=%b expected 0/1",
                     nm, v, bus_if.muldiv_o_ready);
        end
    endtask

    task automatic check_reset_outs(input string nm);
        checks++;
        if (bus_if.muldiv_o_ready !== 1'b1 || bus_if.muldiv_o_stall !== 1'b0 ||
            bus_if.muldiv_o_valid !== 1'b0 || bus_if.muldiv_o_result !== 64'd0 ||
            bus_if.muldiv_o_rd !== 5'd0) begin
            failures++;
            $display("FAIL %s: rdy=%b stl=%b vld=%b res=%h rd=%0d expected 1/0/0/0/0",
                     nm, bus_if.muldiv_o_ready, bus_if.muldiv_o_stall,
                     bus_if.muldiv_o_valid, bus_if.muldiv_o_result,
                     bus_if.muldiv_o_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset_state");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_directed();
        run_op(12, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1,
               64'hFFFF_FFFF_FFFF_FFEB, "mul_7_m3");
        run_op(7, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd2,
               64'hFFFF_FFFF_FFFF_FFFA, "div_m20_3");
        run_op(3, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd3,
               64'hFFFF_FFFF_FFFF_FFFE, "rem_m20_3");
        run_op(6, 64'd5, 64'd0, 5'd4, '1, "divu_by0");
        run_op(2, 64'd5, 64'd0, 5'd5, 64'd5, "remu_by0");
        run_op(7, MIN64, '1, 5'd6, MIN64, "div_ovf");
        run_op(5, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd7,
               64'hFFFF_FFFF_8000_0000, "divw_ovf");
        run_op(8, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd8,
               64'hFFFF_FFFF_FFFF_FFFE, "mulw_sext");
        run_op(11, MIN64, MIN64, 5'd9, 64'h4000_0000_0000_0000, "mulh_min");
        run_op(10, '1, '1, 5'd10, '1, "mulhsu_m1");
    endtask

    task automatic test_random();
        int k;
        logic [63:0] a, b;
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 12);
            a = rnd64();
            b = rnd64();
            run_op(k, a, b, 5'($urandom), model(k, a, b),
                   $sformatf("rand%0d_op%0d", i, k));
        end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        drive(7, 64'd1000, 64'd3, 5'd11);
        @(posedge clk); #1;
        bus_if.execute_i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus_if.execute_i_flush = 1'b1;
        @(posedge clk); #1;
        bus_if.execute_i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.muldiv_o_ready !== 1'b1 || bus_if.muldiv_o_stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: ready=%b stall=%b expected 1/0",
                     bus_if.muldiv_o_ready, bus_if.muldiv_o_stall);
        end
        expect_quiet(80, "after_flush");
        @(posedge clk); #1;
        drive(6, 64'd9, 64'd2, 5'd12);
        bus_if.execute_i_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.muldiv_o_stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_stall: got %b expected 0",
                     bus_if.muldiv_o_stall);
        end
        @(posedge clk); #1;
        idle_inputs();
        expect_quiet(70, "flush_with_start");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive(7, 64'd12345, 64'd7, 5'd13);
        @(posedge clk); #1;
        bus_if.execute_i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outs("async_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        expect_quiet(80, "after_reset");
    endtask

    task automatic test_bad_op();
        @(posedge clk); #1;
        bus_if.execute_i_start = 1'b1;
        bus_if.execute_i_op    = '0;
        @(negedge clk);
        checks++;
        if (bus_if.muldiv_o_stall !== 1'b0) begin
            failures++;
            $display("FAIL zero_op_stall: got %b expected 0", bus_if.muldiv_o_stall);
        end
        @(posedge clk); #1;
        bus_if.execute_i_op = 13'b0_0000_1010_0000;
        @(negedge clk);
        checks++;
        if (bus_if.muldiv_o_stall !== 1'b0) begin
            failures++;
            $display("FAIL multi_op_stall: got %b expected 0", bus_if.muldiv_o_stall);
        end
        @(posedge clk); #1;
        idle_inputs();
        expect_quiet(70, "bad_op");
    endtask

    task automatic test_busy_start();
        int v;
        logic [63:0] got_r;
        logic [4:0]  got_rd;
        v = 0; got_r = 'x; got_rd = 'x;
        @(posedge clk); #1;
        drive(6, 64'd100, 64'd7, 5'd3);
        @(posedge clk); #1;
        bus_if.execute_i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 drive(12, 64'd5, 64'd5, 5'd9);
        @(negedge clk);
        checks++;
        if (bus_if.muldiv_o_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready: got %b expected 0", bus_if.muldiv_o_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (bus_if.muldiv_o_valid === 1'b1) begin
                v++;
                got_r  = bus_if.muldiv_o_result;
                got_rd = bus_if.muldiv_o_rd;
            end
        end
        checks++;
        if (v != 1 || got_r !== 64'd14 || got_rd !== 5'd3) begin
            failures++;
            $display("FAIL busy_start: valids=%0d res=%h rd=%0d expected 1/%h/3",
                     v, got_r, got_rd, 64'd14);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_bad_op();
        test_busy_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have no parameters; XLEN fixed at 64.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 execute_i_start  in  1  request to start an M-extension op this cycle.
REQ-005 execute_i_op  in  13  one-hot op, bit12..0 = mul, mulh, mulhsu, mulhu, mulw, div, divu, divw, divuw, rem, remu, remw, remuw.
REQ-006 execute_i_src1 / execute_i_src2  in  64 each  operands rs1 / rs2.
REQ-007 execute_i_rd  in  5  destination register.
REQ-008 execute_i_flush  in  1  kill any in-flight op.
REQ-009 muldiv_o_ready  out  1  high only in IDLE.
REQ-010 muldiv_o_stall  out  1  holds the upstream pipeline.
REQ-011 muldiv_o_valid  out  1  result strobe.
REQ-012 muldiv_o_result  out  64  result.
REQ-013 muldiv_o_rd  out  5  destination of the result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 Accept occurs at edge E0 when the FSM is in IDLE, execute_i_start=1, execute_i_op is exactly one-hot and execute_i_flush=0; operands, op and rd are latched at E0.
REQ-016 A start with a zero or multi-hot op SHALL be ignored: FSM stays IDLE and stall stays low.
REQ-017 muldiv_o_valid SHALL be high for exactly one cycle, the cycle following edge E0+N, with the FSM in DONE; DONE always returns to IDLE on the next edge.
REQ-018 N values:
- 64 for 64-bit ops;
- 32 for W ops (mulw, divw, divuw, remw, remuw);
- 0 for division special cases (FSM goes IDLE->DONE at E0).
REQ-019 muldiv_o_stall = (IDLE & accept condition true, combinational) | CALC; it SHALL be low in DONE so the pipeline advances with the result.
REQ-020 Multiply SHALL be radix-2 shift-add on operand magnitudes, one bit per CALC cycle, with sign fix-up per op signedness (mulhsu: src1 signed, src2 unsigned).
- mul/mulw return the low half.
- mulh/mulhsu/mulhu return bits 127:64.
REQ-021 Divide SHALL be restoring shift-subtract on magnitudes, one quotient bit per CALC cycle.
- Quotient sign = sign(src1) XOR sign(src2).
- Remainder sign = sign(src1).
REQ-022 Divide by zero: quotient = all ones; remainder = dividend.
REQ-023 Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
REQ-024 Both REQ-022 and REQ-023 are detected at E0 (N=0).
REQ-025 W ops SHALL use src[31:0] only and sign-extend bit 31 of the 32-bit result to 64 bits; the special cases of REQ-022/023 apply at 32-bit width.
REQ-026 muldiv_o_result and muldiv_o_rd SHALL be registered, and held stable from DONE until the next accept.
REQ-027 execute_i_flush=1 in any state SHALL force IDLE on the next edge with no valid pulse; a start in the same cycle is not accepted.
REQ-028 Start asserted in CALC or DONE SHALL be ignored (ready=0).

Reset
REQ-029 On rst low, immediately and without waiting for clk: state=IDLE, datapath registers cleared; outputs read ready=1, stall=0, valid=0, result=0, rd=0.
REQ-030 Reset mid-operation SHALL abandon the op with no valid pulse after release.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN defined: the five multiply ops compute the full 128-bit product combinationally in one CALC cycle (N=1); divides are unchanged.
REQ-032 Macro MULDIV_FAST_MUL_EN undefined: multiplies use the iterative path of REQ-020 with N per REQ-018.

Verification
REQ-033 mul src1=7, src2=0xFFFF_FFFF_FFFF_FFFD -> result 0xFFFF_FFFF_FFFF_FFEB; valid in the cycle after E0+64 (E0+1 with fast mul); stall high from the accept cycle through E0+64 (E0+1 with fast mul), low in DONE.
REQ-034 div src1=-20, src2=3 -> 0xFFFF_FFFF_FFFF_FFFA; rem with the same operands -> 0xFFFF_FFFF_FFFF_FFFE; valid after E0+64.
REQ-035 divu src2=0, src1=5 -> result all ones; remu with the same operands -> 5; div src1=0x8000_0000_0000_0000, src2=-1 -> 0x8000_0000_0000_0000; all valid in the cycle after E0.
REQ-036 divw src1=0x0000_0001_8000_0000, src2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 after E0 (overflow case); mulw 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE after E0+32.
REQ-037 Flush at E0+10 of a div -> IDLE, no valid pulse, ready=1 at E0+11; repeat with rst low at E0+10 -> same outcome; start with op=0 -> no stall, no valid.
